// File: rtl/vc_fifo.sv
// Per-VC flit buffer: NUM_VC circular queues share one write and one read port. Read data is
// fall-through (0 cycles) and flags follow registered counts. Pushes to a full VC are dropped into ovf_err.
module vc_fifo #(
    parameter int DATA_W  = 32,
    parameter int NUM_VC  = 2,
    parameter int DEPTH   = 4,
    parameter int PKT_LEN = 4,
    localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [VC_W-1:0]   wr_vc,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [VC_W-1:0]   rd_vc,
    output logic [DATA_W-1:0] rd_data,
    output logic [NUM_VC-1:0] empty,
    output logic [NUM_VC-1:0] full,
    output logic [NUM_VC-1:0] ordy,
    output logic [NUM_VC-1:0] credit,
    output logic              ovf_err,
    output logic              udf_err
);

    logic [DATA_W-1:0] mem_q [NUM_VC][DEPTH];

    logic [CNT_W-1:0]  cnt_q    [NUM_VC];
    logic [CNT_W-1:0]  cnt_d    [NUM_VC];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_VC];
    logic [NUM_VC-1:0] credit_q, credit_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              wr_vc_ok, rd_vc_ok;
    logic [VC_W-1:0]   wr_idx, rd_idx;
    logic              push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Out-of-range VC indices are steered to VC0 only for array addressing; they never push or pop.
    assign wr_vc_ok = 32'(wr_vc) < 32'(NUM_VC);
    assign rd_vc_ok = 32'(rd_vc) < 32'(NUM_VC);
    assign wr_idx   = wr_vc_ok ? wr_vc : '0;
    assign rd_idx   = rd_vc_ok ? rd_vc : '0;

    always_comb begin
        empty = '0;
        full  = '0;
        ordy  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            empty[v] = (cnt_q[v] == '0);
            full[v]  = (cnt_q[v] == CNT_W'(DEPTH));
            ordy[v]  = ((CNT_W'(DEPTH) - cnt_q[v]) >= CNT_W'(PKT_LEN));
        end
    end

    always_comb begin
        pop   = rd_en & rd_vc_ok & ~empty[rd_idx];
        push  = wr_en & wr_vc_ok & (~full[wr_idx] | (pop & (rd_idx == wr_idx)));
        ovf_d = ovf_q | (wr_en & ~push);
        udf_d = udf_q | (rd_en & ~pop);
        credit_d = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr_d[v] = wr_ptr_q[v];
            rd_ptr_d[v] = rd_ptr_q[v];
            cnt_d[v]    = cnt_q[v];
            if (push && (wr_idx == VC_W'(v))) begin
                wr_ptr_d[v] = ptr_inc(wr_ptr_q[v]);
                cnt_d[v]    = cnt_d[v] + CNT_W'(1);
            end
            if (pop && (rd_idx == VC_W'(v))) begin
                rd_ptr_d[v] = ptr_inc(rd_ptr_q[v]);
                cnt_d[v]    = cnt_d[v] - CNT_W'(1);
                credit_d[v] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_vc_ok && !empty[rd_idx]) begin
            rd_data = mem_q[rd_idx][rd_ptr_q[rd_idx]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                cnt_q[v]    <= '0;
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
            end
            credit_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                cnt_q[v]    <= cnt_d[v];
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
            end
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Payload storage carries no reset; stale entries are unreachable once the counts clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_idx][wr_ptr_q[wr_idx]] <= wr_data;
        end
    end

    assign credit  = credit_q;
    assign ovf_err = ovf_q;
    assign udf_err = udf_q;

endmodule
